// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipe: bubble encoding,
// PC/BTB geometry defaults and the 2-bit branch-predictor counter.
package riscv_pipe_pkg;

   localparam int unsigned PC_W    = 5;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Saturating step: clamps at SNT/ST instead of wrapping.
   function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
      ctr_t r;
      r = c;
      if (taken) begin
         if (c != ST) r = ctr_t'(2'(c) + 2'd1);
      end else begin
         if (c != SNT) r = ctr_t'(2'(c) - 2'd1);
      end
      return r;
   endfunction

   function automatic logic ctr_predicts_taken(input ctr_t c);
      return (c == WT) || (c == ST);
   endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on the fetch PC,
// single-port training from execute. Lookup always sees pre-update state.
module branch_target_buffer
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned PC_W  = riscv_pipe_pkg::PC_W,
   parameter int unsigned IDX_W = riscv_pipe_pkg::IDX_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] pc,
   output logic            pred_taken_c,
   output logic [PC_W-1:0] pred_target_c,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target
);

   localparam int unsigned TAG_W   = PC_W - IDX_W;
   localparam int unsigned ENTRIES = 2 ** IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   ctr_t             ctr_q    [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;

   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   ctr_t             up_ctr;

   // Lookup
   always_comb begin
      lk_idx        = pc[IDX_W-1:0];
      lk_tag        = pc[PC_W-1:IDX_W];
      lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken_c  = lk_hit && ctr_predicts_taken(ctr_q[lk_idx]);
      pred_target_c = target_q[lk_idx];
   end

   // Update decode
   always_comb begin
      up_idx = upd_pc[IDX_W-1:0];
      up_tag = upd_pc[PC_W-1:IDX_W];
      up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_ctr = ctr_step(ctr_q[up_idx], upd_taken);
   end

   // Entries: hits train in place, taken misses allocate, not-taken misses are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= WNT;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            ctr_q[up_idx] <= up_ctr;
            if (upd_taken) target_q[up_idx] <= upd_target;
         end else if (upd_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            ctr_q[up_idx]    <= WT;
         end
      end
   end

endmodule

// File: rtl/fetch_predict_stage.sv
// IF stage: PC register, BTB-predicted next-PC mux and the IF/ID latch.
// Execute redirects override hazard stalls; stalls freeze both PC and IF/ID.
module fetch_predict_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned PC_W  = riscv_pipe_pkg::PC_W,
   parameter int unsigned IDX_W = riscv_pipe_pkg::IDX_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                ex_redirect,
   input  logic [PC_W-1:0]     ex_redirect_pc,
   input  logic                upd_valid,
   input  logic [PC_W-1:0]     upd_pc,
   input  logic                upd_taken,
   input  logic [PC_W-1:0]     upd_target,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  if_ins,
   output logic [PC_W-1:0]     if_pc,
   output logic [PC_W-1:0]     if_nxt,
   output logic                if_pred_taken,
   output logic                if_valid
);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               pred_taken_c;
   logic [PC_W-1:0]    pred_target_c;
   logic [PC_W-1:0]    pred_nxt_c;

   logic [INSTR_W-1:0] ins_d;
   logic [PC_W-1:0]    ifpc_d;
   logic [PC_W-1:0]    nxt_d;
   logic               ptk_d;
   logic               vld_d;

   branch_target_buffer #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W)
   ) u_btb (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc_q),
      .pred_taken_c  (pred_taken_c),
      .pred_target_c (pred_target_c),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target)
   );

   assign imem_addr  = pc_q;
   assign pred_nxt_c = pred_taken_c ? pred_target_c : PC_W'(pc_q + PC_W'(1));

   // Next PC and IF/ID contents: redirect > stall > normal fetch
   always_comb begin
      pc_d   = pc_q;
      ins_d  = if_ins;
      ifpc_d = if_pc;
      nxt_d  = if_nxt;
      ptk_d  = if_pred_taken;
      vld_d  = if_valid;
      if (ex_redirect) begin
         pc_d  = ex_redirect_pc;
         ins_d = NOP_INSTR;
         ptk_d = 1'b0;
         vld_d = 1'b0;
      end else if (!stall) begin
         pc_d   = pred_nxt_c;
         ins_d  = imem_rdata;
         ifpc_d = pc_q;
         nxt_d  = pred_nxt_c;
         ptk_d  = pred_taken_c;
         vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= '0;
         if_ins        <= NOP_INSTR;
         if_pc         <= '0;
         if_nxt        <= '0;
         if_pred_taken <= 1'b0;
         if_valid      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         if_ins        <= ins_d;
         if_pc         <= ifpc_d;
         if_nxt        <= nxt_d;
         if_pred_taken <= ptk_d;
         if_valid      <= vld_d;
      end
   end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage: sequential fetch/wrap, stall, BTB
// allocate/train/alias, same-cycle update, redirect over stall, async reset.
module tb_fetch_predict_stage;

   localparam int unsigned PC_W = 5;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            reset;
   logic            stall;
   logic            ex_redirect;
   logic [PC_W-1:0] ex_redirect_pc;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;
   logic [PC_W-1:0] upd_target;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic [31:0]     if_ins;
   logic [PC_W-1:0] if_pc;
   logic [PC_W-1:0] if_nxt;
   logic            if_pred_taken;
   logic            if_valid;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_predict_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .ex_redirect    (ex_redirect),
      .ex_redirect_pc (ex_redirect_pc),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_ins         (if_ins),
      .if_pc          (if_pc),
      .if_nxt         (if_nxt),
      .if_pred_taken  (if_pred_taken),
      .if_valid       (if_valid)
   );

   always #5 clk = ~clk;

   // imem[i] = i
   assign imem_rdata = 32'(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_fetch(input string tag, input int pc, input int nxt, input logic ptk);
      chk({tag, ".if_pc"},  32'(if_pc),  32'(pc));
      chk({tag, ".if_nxt"}, 32'(if_nxt), 32'(nxt));
      chk({tag, ".if_pred_taken"}, 32'(if_pred_taken), 32'(ptk));
      chk({tag, ".if_valid"}, 32'(if_valid), 32'd1);
      chk({tag, ".if_ins"}, if_ins, 32'(pc));
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".if_valid"}, 32'(if_valid), 32'd0);
      chk({tag, ".if_ins"}, if_ins, NOP);
      chk({tag, ".if_pred_taken"}, 32'(if_pred_taken), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".if_ins"}, if_ins, NOP);
      chk({tag, ".if_pc"}, 32'(if_pc), 32'd0);
      chk({tag, ".if_nxt"}, 32'(if_nxt), 32'd0);
      chk({tag, ".if_pred_taken"}, 32'(if_pred_taken), 32'd0);
      chk({tag, ".if_valid"}, 32'(if_valid), 32'd0);
      chk({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      #1;
      chk_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;

      // Sequential fetch with wrap 31 -> 0
      for (int i = 0; i < 33; i++) begin
         tick();
         chk_fetch("seq", i % 32, (i + 1) % 32, 1'b0);
      end
      // pc = 1; fetch 1,2,3 -> pc = 4
      tick(); tick(); tick();
      chk("pre_stall.if_pc", 32'(if_pc), 32'd3);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall.if_pc", 32'(if_pc), 32'd3);
         chk("stall.imem_addr", 32'(imem_addr), 32'd4);
      end
      stall = 1'b0;
      tick();
      chk_fetch("resume", 4, 5, 1'b0);

      // Allocate pc=6 -> 20 while fetching pc=5
      upd_valid = 1'b1; upd_pc = 5'd6; upd_taken = 1'b1; upd_target = 5'd20;
      tick();
      upd_valid = 1'b0;
      chk_fetch("alloc_fetch5", 5, 6, 1'b0);
      tick();
      chk_fetch("pred6", 6, 20, 1'b1);
      tick();
      chk_fetch("tgt20", 20, 21, 1'b0);

      // Alias: pc=14 shares index 6 with a different tag
      ex_redirect = 1'b1; ex_redirect_pc = 5'd14;
      tick();
      ex_redirect = 1'b0;
      chk_bubble("redir14");
      tick();
      chk_fetch("alias14", 14, 15, 1'b0);

      // Three not-taken: WT->WNT->SNT->SNT (clamped)
      upd_valid = 1'b1; upd_pc = 5'd6; upd_taken = 1'b0;
      tick(); tick(); tick();
      // One taken: SNT->WNT, still predicts not-taken
      upd_taken = 1'b1; upd_target = 5'd20;
      tick();
      upd_valid = 1'b0;
      ex_redirect = 1'b1; ex_redirect_pc = 5'd6;
      tick();
      ex_redirect = 1'b0;
      chk_bubble("redir6a");

      // Same-cycle update (WNT->WT, target 25) while fetching pc=6: old state used
      upd_valid = 1'b1; upd_pc = 5'd6; upd_taken = 1'b1; upd_target = 5'd25;
      tick();
      upd_valid = 1'b0;
      chk_fetch("samecyc6", 6, 7, 1'b0);

      ex_redirect = 1'b1; ex_redirect_pc = 5'd6;
      tick();
      ex_redirect = 1'b0;
      tick();
      chk_fetch("pred6_t25", 6, 25, 1'b1);
      tick();
      chk_fetch("tgt25", 25, 26, 1'b0);

      // Redirect overrides stall
      stall = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 5'd9;
      tick();
      ex_redirect = 1'b0; stall = 1'b0;
      chk_bubble("redir_stall");
      chk("redir_stall.imem_addr", 32'(imem_addr), 32'd9);
      tick();
      chk_fetch("after_redir9", 9, 10, 1'b0);

      // Async reset mid-stall
      stall = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      reset = 1'b0; stall = 1'b0;
      tick();
      chk_fetch("post_rst", 0, 1, 1'b0);

      // BTB cleared by reset
      ex_redirect = 1'b1; ex_redirect_pc = 5'd6;
      tick();
      ex_redirect = 1'b0;
      tick();
      chk_fetch("post_rst6", 6, 7, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
